// File: rtl/hybrid_encrypt_stream.sv
// hybrid_encrypt_stream: two-stage streaming cipher.
//   stage 1 : Vigenere shift of 'A'-'Z' by the current key char (others pass)
//   stage 2 : Polybius 6x6 encoding of letters/digits into two ASCII digits,
//             non-alphanumerics emitted as {8'h00, c}
// Valid/ready on both sides; each stage advances when empty or drained.
// Optional macro HYBRID_ENC_LAST_KEYRESET_EN: a char accepted with in_last
// rewinds the key index to 0 once that char has taken its shift.
module hybrid_encrypt_stream #(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [8*N-1:0]       key,
  input  logic [$clog2(N):0]   key_len,
  input  logic                 key_load,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_char,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          out_code,
  output logic                 out_last
);

  localparam int STAGES = 2;
  localparam int LW     = $clog2(N) + 1;
  localparam int IW     = (N > 1) ? $clog2(N) : 1;

  typedef struct packed {
    logic [7:0] ch;
    logic       last;
  } s1_t;

  // key storage: char j lives at key_q[N-1-j], matching the packed port layout
  logic [N-1:0][7:0] key_q;
  logic [LW-1:0]     klen_q;
  logic [IW-1:0]     kidx_q;

  logic [STAGES:1]   vld_pipe;
  s1_t               s1_q;

  logic [LW-1:0]     klen_eff;
  logic [IW-1:0]     kidx_nxt;
  logic [IW-1:0]     ki;
  logic [7:0]        kch;
  logic [4:0]        shift;
  logic [5:0]        sum;
  logic              in_is_letter;
  logic [7:0]        s1_ch_d;
  logic              in_fire;
  logic              s1_adv;
  logic              s2_adv;

  logic              s2_letter;
  logic              s2_digit;
  logic [5:0]        sym;
  logic [5:0]        row;
  logic [5:0]        col;
  logic [15:0]       enc;

  // handshake: a stage may load when it is empty or its contents leave this cycle
  always_comb begin
    s2_adv   = !vld_pipe[2] || out_ready;
    s1_adv   = !vld_pipe[1] || s2_adv;
    in_ready = rst_n && !key_load && s1_adv;
    in_fire  = in_valid && in_ready;
  end

  assign out_valid = vld_pipe[2];

  // clamp the requested key length into 1..N
  always_comb begin
    if (key_len == '0)
      klen_eff = LW'(1);
    else if (key_len > LW'(N))
      klen_eff = LW'(N);
    else
      klen_eff = key_len;
  end

  // stage 1 datapath: pick key char, derive shift, rotate letters mod 26
  always_comb begin
    ki           = IW'(N - 1) - kidx_q;
    kch          = key_q[ki];
    shift        = (kch >= 8'h41 && kch <= 8'h5A) ? 5'(kch - 8'h41) : 5'd0;
    in_is_letter = (in_char >= 8'h41) && (in_char <= 8'h5A);
    sum          = 6'(in_char - 8'h41) + 6'(shift);
    if (sum >= 6'd26)
      sum = sum - 6'd26;
    s1_ch_d      = in_is_letter ? (8'h41 + 8'(sum)) : in_char;
    kidx_nxt     = ((LW'(kidx_q) + LW'(1)) >= klen_q) ? '0 : (kidx_q + IW'(1));
  end

  // stage 2 datapath: symbol index -> row/col on the 6x6 grid
  always_comb begin
    s2_letter = (s1_q.ch >= 8'h41) && (s1_q.ch <= 8'h5A);
    s2_digit  = (s1_q.ch >= 8'h30) && (s1_q.ch <= 8'h39);
    sym       = s2_letter ? 6'(s1_q.ch - 8'h41) : (6'(s1_q.ch - 8'h30) + 6'd26);
    row       = sym / 6'd6;
    col       = sym % 6'd6;
    if (s2_letter || s2_digit)
      enc = {8'h31 + 8'(row), 8'h31 + 8'(col)};
    else
      enc = {8'h00, s1_q.ch};
  end

  // key register and key index; only letters consume a key char
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q  <= '0;
      klen_q <= LW'(1);
      kidx_q <= '0;
    end else if (key_load) begin
      key_q  <= key;
      klen_q <= klen_eff;
      kidx_q <= '0;
    end else if (in_fire) begin
      if (in_is_letter)
        kidx_q <= kidx_nxt;
`ifdef HYBRID_ENC_LAST_KEYRESET_EN
      if (in_last)
        kidx_q <= '0;
`endif
    end
  end

  // stage 1 register: shifted char plus its last flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      s1_q        <= '0;
    end else if (s1_adv) begin
      vld_pipe[1] <= in_fire;
      if (in_fire) begin
        s1_q.ch   <= s1_ch_d;
        s1_q.last <= in_last;
      end
    end
  end

  // stage 2 register: drives the output port; holds while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe[2] <= 1'b0;
      out_code    <= '0;
      out_last    <= 1'b0;
    end else if (s2_adv) begin
      vld_pipe[2] <= vld_pipe[1];
      if (vld_pipe[1]) begin
        out_code <= enc;
        out_last <= s1_q.last;
      end else begin
        out_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hybrid_encrypt_stream.sv
// Directed bench for hybrid_encrypt_stream (N=4). Expected {last,code}
// values are queued when a char is accepted and popped as outputs leave.
module tb_hybrid_encrypt_stream;
  localparam int N  = 4;
  localparam int LW = $clog2(N) + 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [8*N-1:0] key;
  logic [LW-1:0]  key_len;
  logic           key_load;
  logic           in_valid, in_ready, in_last;
  logic [7:0]     in_char;
  logic           out_valid, out_ready, out_last;
  logic [15:0]    out_code;

  hybrid_encrypt_stream #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .key_len(key_len), .key_load(key_load),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int n_out  = 0;
  logic [16:0] exp_q[$];
  int out_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // output scoreboard and stall-stability check, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_chk++;
      assert (exp_q.size() != 0) n_pass++;
      else $error("FAIL spurious_out observed=%h expected=none", out_code);
      if (exp_q.size() != 0) chk("out", {15'd0, out_last, out_code}, {15'd0, exp_q.pop_front()});
      n_out++;
      out_cyc.push_back(cyc);
    end else if (rst_n && out_valid && !out_ready && exp_q.size() != 0) begin
      chk("stall_hold", {15'd0, out_last, out_code}, {15'd0, exp_q[0]});
    end
  end

  function automatic logic [8*N-1:0] mk_key(input string s);
    logic [8*N-1:0] k = '0;
    for (int j = 0; j < s.len() && j < N; j++) k[8*(N-1-j) +: 8] = s[j];
    return k;
  endfunction

  // call at posedge+1; returns at posedge+1 of the cycle after acceptance
  task automatic send(input logic [7:0] c, input logic l, input logic [15:0] exp);
    bit done = 0;
    in_char = c; in_last = l; in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({l, exp});
        done = 1;
      end
    end
    if (!done) begin
      n_chk++;
      $error("FAIL accept_timeout observed=stalled expected=accept char=%h", c);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // in_valid is held high during the load to show no char slips in
  task automatic load_key(input string s, input int len);
    key = mk_key(s); key_len = LW'(len); key_load = 1'b1;
    in_valid = 1'b1; in_char = 8'h5A; in_last = 1'b0;
    @(negedge clk);
    chk("load_blocks_in", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    key_load = 1'b0; in_valid = 1'b0;
  endtask

  task automatic drain();
    int i = 0;
    while (exp_q.size() != 0 && i < 60) begin
      @(posedge clk); i++;
    end
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; key = '0; key_len = '0; key_load = 1'b0;
    in_valid = 1'b0; in_char = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_in_ready",  {31'd0, in_ready}, 0);
    chk("rst_out_code",  {16'd0, out_code}, 0);
    chk("rst_out_last",  {31'd0, out_last}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", {31'd0, in_ready}, 1);
    @(posedge clk); #1;

    // stored key cleared by reset -> shift 0
    send(8'h43, 1'b0, 16'h3133);
    drain();

    // "KEY": 'H' -> 'R', output exactly two cycles after acceptance
    load_key("KEY", 3);
    send(8'h48, 1'b0, 16'h3336);
    @(negedge clk);
    chk("lat_cycle1", {31'd0, out_valid}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_cycle2", {31'd0, out_valid}, 1);
    @(posedge clk); #1;
    drain();

    // "B": only the letter takes a shift
    load_key("B", 1);
    send(8'h5A, 1'b0, 16'h3131);
    send(8'h35, 1'b0, 16'h3632);
    send(8'h21, 1'b0, 16'h0021);
    drain();

    // "AB": key index wraps, one output per cycle
    load_key("AB", 2);
    out_cyc.delete();
    send(8'h41, 1'b0, 16'h3131);
    send(8'h41, 1'b0, 16'h3132);
    send(8'h41, 1'b0, 16'h3131);
    drain();
    chk("throughput", out_cyc[2] - out_cyc[0], 2);

    // key_len 0 behaves as 1
    load_key("BC", 0);
    send(8'h41, 1'b0, 16'h3132);
    send(8'h41, 1'b0, 16'h3132);
    drain();

    // key_len above N clamps to N
    load_key("BCDE", 7);
    send(8'h41, 1'b0, 16'h3132);
    send(8'h41, 1'b0, 16'h3133);
    send(8'h41, 1'b0, 16'h3134);
    send(8'h41, 1'b0, 16'h3135);
    send(8'h41, 1'b0, 16'h3132);
    drain();

    // backpressure: two accepts fill the pipe, then input stalls
    load_key("AB", 2);
    base = n_out;
    out_ready = 1'b0;
    send(8'h41, 1'b0, 16'h3131);
    send(8'h42, 1'b0, 16'h3133);
    @(negedge clk);
    chk("bp_in_ready", {31'd0, in_ready}, 0);
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b1;
    send(8'h43, 1'b0, 16'h3133);
    send(8'h44, 1'b0, 16'h3135);
    drain();
    chk("bp_count", n_out - base, 4);

    // in_last handling
    load_key("KEY", 3);
    send(8'h41, 1'b1, 16'h3235);
`ifdef HYBRID_ENC_LAST_KEYRESET_EN
    send(8'h41, 1'b0, 16'h3235);
    send(8'h41, 1'b0, 16'h3135);
`else
    send(8'h41, 1'b0, 16'h3135);
    send(8'h41, 1'b0, 16'h3531);
`endif
    drain();

    // reset with two chars in flight discards them
    load_key("KEY", 3);
    out_ready = 1'b0;
    send(8'h41, 1'b0, 16'h3235);
    send(8'h41, 1'b0, 16'h3135);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 0);
    chk("midrst_out_last",  {31'd0, out_last}, 0);
    chk("midrst_in_ready",  {31'd0, in_ready}, 0);
    exp_q.delete();
    base = n_out;
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    load_key("DOG", 3);
    send(8'h41, 1'b0, 16'h3134);
    drain();
    chk("midrst_no_stale", n_out - base, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
